hash_seq: RTL and testbench

HASH_SEQ -- requirements
Module: hash_seq

---
 rtl/hash_seq.sv | 116 +++++++++++
 tb/tb_hash_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hash_seq.sv
// hash_seq: packs key bytes big-endian into 12-byte blocks, strobes them to a hash core
// and returns the captured hash after the core latency.
module hash_seq #(
    parameter int HASH_LATENCY = 4,
    parameter int MAX_LEN      = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  key_len,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        hash_enable,
    output logic        hash_last,
    output logic [7:0]  hash_key_length,
    output logic [31:0] hash_k0,
    output logic [31:0] hash_k1,
    output logic [31:0] hash_k2,
    input  logic [31:0] hash_result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] result,
    output logic        busy
);
    localparam int WW = $clog2(HASH_LATENCY + 2);
    localparam logic [8:0] MAX9 = 9'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic [7:0]      cnt;
    logic [3:0]      idx;
    logic [95:0]     k;
    logic [WW-1:0]   wcnt;

    assign hash_k0 = k[95:64];
    assign hash_k1 = k[63:32];
    assign hash_k2 = k[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            idx             <= '0;
            k               <= '0;
            wcnt            <= '0;
            hash_key_length <= '0;
            byte_ready      <= 1'b0;
            hash_enable     <= 1'b0;
            hash_last       <= 1'b0;
            result_valid    <= 1'b0;
            result          <= '0;
            busy            <= 1'b0;
        end else begin
            hash_enable <= 1'b0;
            case (state)
                IDLE: if (start && {1'b0, key_len} <= MAX9) begin
                    hash_key_length <= key_len;
                    cnt             <= '0;
                    idx             <= '0;
                    k               <= '0;
                    busy            <= 1'b1;
                    if (key_len == 8'd0) begin
                        state       <= ISSUE;
                        hash_enable <= 1'b1;
                        hash_last   <= 1'b1;
                    end else begin
                        state      <= LOAD;
                        byte_ready <= 1'b1;
                    end
                end
                LOAD: if (byte_valid && byte_ready) begin
                    for (int i = 0; i < 12; i++)
                        if (idx == 4'(i)) k[95-8*i -: 8] <= byte_data;
                    cnt <= cnt + 8'd1;
                    idx <= idx + 4'd1;
                    // block closes on a full 12 bytes or the final key byte
                    if (idx == 4'd11 || cnt + 8'd1 == hash_key_length) begin
                        state       <= ISSUE;
                        byte_ready  <= 1'b0;
                        hash_enable <= 1'b1;
                        hash_last   <= (cnt + 8'd1 == hash_key_length);
                    end
                end
                ISSUE: begin
                    hash_last <= 1'b0;
                    if (hash_last) begin
                        state <= WAIT;
                        wcnt  <= WW'(HASH_LATENCY);
                    end else begin
                        state      <= LOAD;
                        byte_ready <= 1'b1;
                        k          <= '0;
                        idx        <= '0;
                    end
                end
                WAIT: begin
                    wcnt <= wcnt - WW'(1);
                    // capture on the cycle the core output becomes valid
                    if (wcnt <= WW'(1)) begin
                        result       <= hash_result;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: if (result_ready) begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_seq.sv
// tb_hash_seq: directed and randomized keys checked against a block-level model of hash_seq.
module tb_hash_seq;
    localparam int HL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  key_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, hash_enable, hash_last, result_valid, busy;
    logic [7:0]  hash_key_length;
    logic [31:0] hash_k0, hash_k1, hash_k2, result;
    logic [31:0] hash_result = '0;
    logic        result_ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          np = 0;
    int          last_cyc = 0;
    logic [31:0] hr [0:16383];
    logic [95:0] p_k [0:63];
    logic        p_last [0:63];
    logic [7:0]  kb [0:255];

    hash_seq #(.HASH_LATENCY(HL), .MAX_LEN(255)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .hash_enable(hash_enable), .hash_last(hash_last), .hash_key_length(hash_key_length),
        .hash_k0(hash_k0), .hash_k1(hash_k1), .hash_k2(hash_k2), .hash_result(hash_result),
        .result_valid(result_valid), .result_ready(result_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one cycle; record core output per cycle and every block strobe
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        hash_result = $urandom;
        hr[cyc] = hash_result;
        if (hash_enable) begin
            p_k[np] = {hash_k0, hash_k1, hash_k2};
            p_last[np] = hash_last;
            last_cyc = cyc;
            if (np < 63) np++;
        end
    endtask

    task automatic set_str(input string s);
        for (int i = 0; i < 256; i++) kb[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) kb[i] = s[i];
    endtask

    task automatic set_rand;
        for (int i = 0; i < 256; i++) kb[i] = 8'($urandom);
    endtask

    task automatic run_key(input int len, input int gap_pct, input int rdelay, input bit poke);
        int pos = 0, budget = 4000, rdy_seen = 0, bad = 0, nblk, bi;
        bit acc;
        logic [95:0] blk;
        logic [31:0] hold;
        np = 0;
        last_cyc = 0;
        nblk = (len == 0) ? 1 : (len + 11) / 12;
        start = 1'b1;
        key_len = 8'(len);
        tick;
        start = 1'b0;
        while (!result_valid && budget > 0) begin
            byte_valid = (pos < len) && ($urandom_range(99) >= gap_pct);
            byte_data = kb[pos];
            if (poke) begin
                start = ($urandom_range(3) == 0);
                key_len = 8'($urandom);
            end
            acc = byte_valid && byte_ready;
            if (byte_ready) rdy_seen++;
            tick;
            budget--;
            if (acc) pos++;
        end
        byte_valid = 1'b0;
        start = 1'b0;
        chk("result_timeout", budget > 0, 1'b1);
        chk("bytes_taken", pos, len);
        chk("key_length", hash_key_length, len);
        chk("pulse_count", np, nblk);
        for (int b = 0; b < nblk && b < np; b++) begin
            for (int j = 0; j < 12; j++) begin
                bi = b * 12 + j;
                blk[95-8*j -: 8] = (bi < len) ? kb[bi] : 8'h00;
            end
            chk("block", {p_last[b], p_k[b]}, {b == nblk - 1, blk});
        end
        if (len == 0) chk("no_byte_ready", rdy_seen, 0);
        chk("rv_latency", cyc, last_cyc + HL + 1);
        chk("result", result, hr[last_cyc + HL]);
        hold = result;
        repeat (rdelay) begin
            tick;
            if (!(result_valid === 1'b1 && result === hold)) bad++;
        end
        if (rdelay > 0) chk("result_hold", bad, 0);
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
        chk("done_exit", {result_valid, busy}, 2'b00);
    endtask

    initial begin
        int pos;
        bit acc;
        for (int i = 0; i < 16384; i++) hr[i] = '0;
        tick;
        tick;
        chk("reset_ctrl", {byte_ready, hash_enable, hash_last, result_valid, busy}, 5'b0);
        chk("reset_data", {hash_k0, hash_k1, hash_k2, hash_key_length, result}, '0);
        rst_n = 1'b1;
        tick;
        chk("idle_busy", busy, 1'b0);

        set_str("abc");
        run_key(3, 0, 0, 1'b0);
        chk("abc_k", {p_last[0], p_k[0]}, {1'b1, 32'h61626300, 64'h0});

        set_str("abcdefghijkl");
        run_key(12, 0, 2, 1'b0);
        chk("abc12_k", {p_last[0], p_k[0]}, {1'b1, 96'h6162636465666768696A6B6C});

        set_str("abcdefghijklmno");
        run_key(15, 30, 0, 1'b0);
        chk("abc15_first", {p_last[0], p_k[0]}, {1'b0, 96'h6162636465666768696A6B6C});
        chk("abc15_second", {p_last[1], p_k[1]}, {1'b1, 32'h6D6E6F00, 64'h0});

        set_rand;
        run_key(0, 50, 1, 1'b0);
        chk("zero_k", {p_last[0], p_k[0]}, {1'b1, 96'h0});

        set_rand;
        run_key(250, 40, 5, 1'b1);
        set_rand;
        run_key(24, 20, 0, 1'b1);
        set_rand;
        run_key(1, 60, 3, 1'b0);

        // reset asserted mid-load, between clock edges
        set_rand;
        start = 1'b1;
        key_len = 8'd100;
        tick;
        start = 1'b0;
        pos = 0;
        repeat (30) begin
            byte_valid = 1'b1;
            byte_data = kb[pos];
            acc = byte_ready;
            tick;
            if (acc) pos++;
        end
        chk("mid_load_busy", {busy, hash_key_length}, {1'b1, 8'd100});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {byte_ready, hash_enable, hash_last, result_valid, busy}, 5'b0);
        chk("async_rst_data", {hash_k0, hash_k1, hash_k2, hash_key_length, result}, '0);
        np = 0;
        repeat (3) tick;
        rst_n = 1'b1;
        repeat (20) tick;
        byte_valid = 1'b0;
        chk("no_pulse_after_rst", np, 0);
        chk("idle_after_rst", {busy, byte_ready}, 2'b00);

        set_str("xyz");
        run_key(3, 0, 0, 1'b0);
        chk("post_rst_k", {p_last[0], p_k[0]}, {1'b1, 32'h78797A00, 64'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
